// File: rtl/mult_div_unit_if.sv
// Handshake/bus bundle between the EX stage and the iterative multiply/divide unit.
// The master side launches operations and MTHI/MTLO writes; the slave side is the unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, rs_val, rt_val, wr_hi, wr_lo, wr_data,
        input  hi_out, lo_out, busy, done, div_zero
    );

    modport slave (
        input  start, op, rs_val, rt_val, wr_hi, wr_lo, wr_data,
        output hi_out, lo_out, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// Operates on magnitudes for WIDTH cycles, then applies sign fix-up in a single FINISH cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);
    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FINISH = 2'b10
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic             is_div_r;
    logic             neg_a_r;
    logic             neg_b_r;
    logic             dz_r;
    logic [WIDTH-1:0] mag_a_r;
    logic [WIDTH-1:0] mag_b_r;
    logic [DW-1:0]    acc_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;
    logic             div_zero_r;

    logic [WIDTH-1:0] mag_rs_s;
    logic [WIDTH-1:0] mag_rt_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [DW-1:0]    mul_acc_next_s;
    logic [WIDTH:0]   div_shift_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;
    logic [DW-1:0]    prod_fix_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;
    logic [WIDTH-1:0] raw_a_s;
    logic [WIDTH-1:0] hi_res_s;
    logic [WIDTH-1:0] lo_res_s;

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = ~v + WIDTH'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] cond_neg_dw(input logic [DW-1:0] v, input logic neg);
        logic [DW-1:0] r;
        if (neg) begin
            r = ~v + DW'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Operand magnitudes at launch; only the signed ops (op[0]=1) treat the MSB as a sign.
    always_comb begin
        mag_rs_s = cond_neg_w(bus.rs_val, bus.op[0] & bus.rs_val[WIDTH-1]);
        mag_rt_s = cond_neg_w(bus.rt_val, bus.op[0] & bus.rt_val[WIDTH-1]);
    end

    // One shift-add multiply step: multiplier sits in acc low half, product grows into the top.
    always_comb begin
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[DW-1:WIDTH]} + {1'b0, mag_b_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[DW-1:WIDTH]};
        end
        mul_acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end

    // One restoring divide step: dividend/quotient shifts through acc low half.
    // The remainder stays below the divisor, so only the shifted value needs the extra bit.
    always_comb begin
        div_shift_s = {rem_r, acc_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, mag_b_r});
        if (div_ge_s) begin
            rem_next_s = WIDTH'(div_shift_s - {1'b0, mag_b_r});
            quo_next_s = {acc_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = div_shift_s[WIDTH-1:0];
            quo_next_s = {acc_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up and result selection used at the edge leaving FINISH.
    always_comb begin
        prod_fix_s = cond_neg_dw(acc_r, neg_a_r ^ neg_b_r);
        quo_fix_s  = cond_neg_w(acc_r[WIDTH-1:0], neg_a_r ^ neg_b_r);
        rem_fix_s  = cond_neg_w(rem_r, neg_a_r);
        raw_a_s    = cond_neg_w(mag_a_r, neg_a_r);
        if (!is_div_r) begin
            hi_res_s = prod_fix_s[DW-1:WIDTH];
            lo_res_s = prod_fix_s[WIDTH-1:0];
        end else if (dz_r) begin
            hi_res_s = raw_a_s;
            lo_res_s = {WIDTH{1'b1}};
        end else begin
            hi_res_s = rem_fix_s;
            lo_res_s = quo_fix_s;
        end
    end

    // Control FSM plus datapath and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CW{1'b0}};
            is_div_r   <= 1'b0;
            neg_a_r    <= 1'b0;
            neg_b_r    <= 1'b0;
            dz_r       <= 1'b0;
            mag_a_r    <= {WIDTH{1'b0}};
            mag_b_r    <= {WIDTH{1'b0}};
            acc_r      <= {DW{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        is_div_r <= bus.op[1];
                        neg_a_r  <= bus.op[0] & bus.rs_val[WIDTH-1];
                        neg_b_r  <= bus.op[0] & bus.rt_val[WIDTH-1];
                        dz_r     <= bus.op[1] & (bus.rt_val == {WIDTH{1'b0}});
                        mag_a_r  <= mag_rs_s;
                        mag_b_r  <= mag_rt_s;
                        acc_r    <= {{WIDTH{1'b0}}, mag_rs_s};
                        rem_r    <= {WIDTH{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= ST_RUN;
                    end else begin
                        if (bus.wr_hi) begin
                            hi_r <= bus.wr_data;
                        end
                        if (bus.wr_lo) begin
                            lo_r <= bus.wr_data;
                        end
                    end
                end
                ST_RUN: begin
                    if (is_div_r) begin
                        acc_r <= {acc_r[DW-1:WIDTH], quo_next_s};
                        rem_r <= rem_next_s;
                    end else begin
                        acc_r <= mul_acc_next_s;
                    end
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        state_r <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    hi_r       <= hi_res_s;
                    lo_r       <= lo_res_s;
                    done_r     <= 1'b1;
                    div_zero_r <= dz_r;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.hi_out   = hi_r;
    assign bus.lo_out   = lo_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = div_zero_r;
endmodule
